// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its storage array.
package mem_pkg;

    // Responder control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } MemState_t;

    localparam int WORD_W = 32;  // data word width
    localparam int BE_W   = 4;   // byte strobes per word
    localparam int LAT_W  = 4;   // wait-state counter width (LATENCY 0..15)

    // Alignment fault: low address bits set while the alignment check is enabled.
    function automatic logic align_fault(input logic [1:0] addr_lo, input logic check_en);
        return check_en & (|addr_lo);
    endfunction

endpackage

// File: rtl/mem_sram_array.sv
// Single-port word array with per-byte write enable and a registered read port.
// Read-first: a read returns the word as it was before any write on the same edge.
// No reset, so the array maps onto block RAM.
module mem_sram_array
    import mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic                           i_Clk,
    input  logic                           i_En,
    input  logic [BE_W-1:0]                i_We,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_Addr,
    input  logic [WORD_W-1:0]              i_WData,
    output logic [WORD_W-1:0]              o_RData
);

    logic [WORD_W-1:0] r_Mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_RData;

    // Byte-lane writes and registered read, both gated by the access enable.
    always_ff @(posedge i_Clk) begin
        if (i_En) begin
            for (int k = 0; k < BE_W; k++) begin
                if (i_We[k]) begin
                    r_Mem[i_Addr][8*k +: 8] <= i_WData[8*k +: 8];
                end
            end
            r_RData <= r_Mem[i_Addr];
        end
    end

    assign o_RData = r_RData;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle core: one outstanding request,
// LATENCY wait cycles, then one array access cycle, then a held response.
// Optional build macro: MEM_ALIGN_CHECK_EN (fault requests with addr[1:0] != 0;
// when undefined the low address bits are ignored and access is word-forced).
module mem_responder
    import mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_ReqValid,
    output logic              o_ReqReady,
    input  logic              i_ReqWrite,
    input  logic [31:0]       i_ReqAddr,
    input  logic [WORD_W-1:0] i_ReqWData,
    input  logic [BE_W-1:0]   i_ReqByteEn,
    output logic              o_RspValid,
    input  logic              i_RspReady,
    output logic [WORD_W-1:0] o_RspRData,
    output logic              o_RspErr
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    MemState_t         r_State;
    MemState_t         w_NextState;
    logic [LAT_W-1:0]  r_Cnt;
    logic              r_ReqReady;
    logic              r_RspValid;

    logic              r_Write;
    logic              r_Err;
    logic [AW-1:0]     r_Idx;
    logic [WORD_W-1:0] r_WData;
    logic [BE_W-1:0]   r_ByteEn;

    logic              w_Accept;
    logic              w_RangeErr;
    logic              w_AlignErr;
    logic              w_Access;
    logic              w_SramEn;
    logic [BE_W-1:0]   w_SramWe;
    logic [WORD_W-1:0] w_SramQ;

    // Ready is only ever high in IDLE, so a plain AND is the accept condition.
    assign w_Accept   = i_ReqValid & r_ReqReady;
    assign w_RangeErr = |i_ReqAddr[31:AW+2];
    assign w_AlignErr = align_fault(i_ReqAddr[1:0], ALIGN_EN);

    // The first RESP cycle is the array access; o_RspValid rises on that edge.
    assign w_Access = (r_State == RESP) & ~r_RspValid;
    assign w_SramEn = w_Access & ~r_Err;
    assign w_SramWe = (w_SramEn & r_Write) ? r_ByteEn : '0;

    // Next-state logic for the single-outstanding-request handshake.
    always_comb begin
        w_NextState = r_State;
        case (r_State)
            IDLE: if (w_Accept) w_NextState = (LATENCY > 0) ? WAIT : RESP;
            WAIT: if (r_Cnt == LAT_LAST) w_NextState = RESP;
            RESP: if (r_RspValid & i_RspReady) w_NextState = IDLE;
            default: w_NextState = IDLE;
        endcase
    end

    // Control state: FSM, wait counter, ready and response-valid flags.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_State    <= IDLE;
            r_Cnt      <= '0;
            r_ReqReady <= 1'b0;
            r_RspValid <= 1'b0;
        end else begin
            r_State    <= w_NextState;
            r_ReqReady <= (w_NextState == IDLE);
            r_Cnt      <= (r_State == WAIT && w_NextState == WAIT) ? r_Cnt + 1'b1 : '0;
            if (w_Access) begin
                r_RspValid <= 1'b1;
            end else if (r_RspValid & i_RspReady) begin
                r_RspValid <= 1'b0;
            end
        end
    end

    // Request capture on accept so the core may change its inputs afterwards.
    always_ff @(posedge i_Clk) begin
        if (w_Accept) begin
            r_Write  <= i_ReqWrite;
            r_Err    <= w_RangeErr | w_AlignErr;
            r_Idx    <= i_ReqAddr[AW+1:2];
            r_WData  <= i_ReqWData;
            r_ByteEn <= i_ReqByteEn;
        end
    end

    mem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_sram (
        .i_Clk   (i_Clk),
        .i_En    (w_SramEn),
        .i_We    (w_SramWe),
        .i_Addr  (r_Idx),
        .i_WData (r_WData),
        .o_RData (w_SramQ)
    );

    // The array output holds after the access, so the response stays stable under backpressure.
    assign o_ReqReady = r_ReqReady;
    assign o_RspValid = r_RspValid;
    assign o_RspErr   = r_RspValid & r_Err;
    assign o_RspRData = (r_RspValid & ~r_Err & ~r_Write) ? w_SramQ : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: main instance at LATENCY=2, second at LATENCY=0.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_rsp_ready = 1'b0;
    logic [31:0] z_req_addr = '0, z_req_wdata = '0;
    logic [3:0]  z_req_be = '0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .i_Clk(clk), .i_Reset(rst_n),
        .i_ReqValid(req_valid), .o_ReqReady(req_ready), .i_ReqWrite(req_write),
        .i_ReqAddr(req_addr), .i_ReqWData(req_wdata), .i_ReqByteEn(req_be),
        .o_RspValid(rsp_valid), .i_RspReady(rsp_ready),
        .o_RspRData(rsp_rdata), .o_RspErr(rsp_err)
    );

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_lat0 (
        .i_Clk(clk), .i_Reset(rst_n),
        .i_ReqValid(z_req_valid), .o_ReqReady(z_req_ready), .i_ReqWrite(z_req_write),
        .i_ReqAddr(z_req_addr), .i_ReqWData(z_req_wdata), .i_ReqByteEn(z_req_be),
        .o_RspValid(z_rsp_valid), .i_RspReady(z_rsp_ready),
        .o_RspRData(z_rsp_rdata), .o_RspErr(z_rsp_err)
    );

    // One full transaction on the LATENCY=2 instance; lat = edges from accept to RspValid.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFFC; req_wdata = '0; req_be = 4'hF;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    // Same transaction on the LATENCY=0 instance.
    task automatic zxact(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd, output logic er,
                         output int lat);
        int n = 0;
        @(negedge clk);
        z_req_valid = 1'b1; z_req_write = w; z_req_addr = a; z_req_wdata = d; z_req_be = be;
        while (!z_req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        z_req_valid = 1'b0; z_req_addr = 32'hFFFF_FFFC; z_req_wdata = '0;
        lat = 0;
        while (!z_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        rd = z_rsp_rdata; er = z_rsp_err;
        z_rsp_ready = 1'b1; @(posedge clk); #1; z_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_pre got=%b exp=0", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL store_latency got=%0d exp=3", lat); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_err got=%b exp=0", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata got=%h exp=0", rd); end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL load_latency got=%0d exp=3", lat); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata got=%h exp=deadbeef", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL load_err got=%b exp=0", er); end
    endtask

    task automatic test_byte_strobes();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL byte_strobe_rdata got=%h exp=11bb33dd", rd); end
    endtask

    task automatic test_backpressure();
        int n = 0; int lat = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_addr = 32'h20;   // a second request stays pending during the held response
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, rsp_valid); end
            n_checks++; if (rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_rdata[%0d] got=%h exp=deadbeef", i, rsp_rdata); end
            n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_err[%0d] got=%b exp=0", i, rsp_err); end
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_reqready[%0d] got=%b exp=0", i, req_ready); end
        end
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_fall got=%b exp=0", rsp_valid); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_same_cycle got=%b exp=1", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept got=%b exp=0", req_ready); end
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        n_checks++; if (rsp_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL bp_second_rdata got=%h exp=11bb33dd", rsp_rdata); end
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
        xact(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL range_store_err got=%b exp=1", er); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL range_latency got=%0d exp=3", lat); end
        xact(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL range_load_err got=%b exp=1", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL range_load_rdata got=%h exp=0", rd); end
        xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL range_word0 got=%h exp=0badf00d", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL range_word0_err got=%b exp=0", er); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat; int n = 0;
        xact(1'b1, 32'h30, 32'h12345678, 4'hF, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL midwait_ready got=%b exp=0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midwait_valid got=%b exp=0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL midwait_rdata got=%h exp=0", rsp_rdata); end
        @(posedge clk); @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midwait_release_ready got=%b exp=1", req_ready); end
        xact(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL midwait_no_commit got=%h exp=12345678", rd); end
    endtask

    task automatic test_latency0();
        logic [31:0] rd; logic er; int lat;
        zxact(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, rd, er, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL lat0_store_latency got=%0d exp=1", lat); end
        zxact(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL lat0_load_latency got=%0d exp=1", lat); end
`ifdef MEM_ALIGN_CHECK_EN
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL lat0_align_err got=%b exp=1", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL lat0_align_rdata got=%h exp=0", rd); end
`else
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL lat0_err got=%b exp=0", er); end
        n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat0_rdata got=%h exp=cafef00d", rd); end
`endif
        zxact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat0_word10 got=%h exp=cafef00d", rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_strobes();
        test_backpressure();
        test_range();
        test_reset_mid_wait();
        test_latency0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
